// File: rtl/pc_sequencer.sv
// Next-PC controller: boot window, redirect priority (trap > branch > jump) and
// replay of redirects that arrive while imem is busy. Optional: PC_ALIGN_CHECK_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0004,
  parameter int unsigned BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        imem_ready,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp_valid,
  input  logic [31:0] jmp_target,
  input  logic        trap_req,
  output logic [31:0] npc,
  output logic        stall_PC,
  output logic        flush_IF,
  output logic        flush_ID,
  output logic        redirect_pending,
  output logic        boot_done,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Source tag doubles as priority: larger value wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JMP  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } src_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pend_q, pend_d;
  src_t        tag_q, tag_d;

  src_t        req_src;
  logic [31:0] req_tgt;
  logic        take_new;
`ifdef PC_ALIGN_CHECK_EN
  logic        req_misalign;
`endif

  always_comb begin
    req_src = SRC_NONE;
    req_tgt = '0;
    if (trap_req) begin
      req_src = SRC_TRAP;
      req_tgt = TRAP_VECTOR;
    end else if (br_taken) begin
      req_src = SRC_BR;
      req_tgt = br_target;
    end else if (jmp_valid) begin
      req_src = SRC_JMP;
      req_tgt = jmp_target;
    end
`ifdef PC_ALIGN_CHECK_EN
    req_misalign = 1'b0;
    if ((req_src == SRC_BR || req_src == SRC_JMP) && req_tgt[1:0] != 2'b00) begin
      req_misalign = 1'b1;
      req_src      = SRC_TRAP;
      req_tgt      = TRAP_VECTOR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= '0;
      pend_q     <= '0;
      tag_q      <= SRC_NONE;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pend_q     <= pend_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pend_d     = pend_q;
    tag_d      = tag_q;
    npc        = RESET_VECTOR;
    stall_PC   = 1'b1;
    flush_IF   = 1'b1;
    flush_ID   = 1'b1;
    take_new   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        flush_IF = 1'b0;
        flush_ID = 1'b0;
        if (req_src != SRC_NONE) begin
          flush_IF = 1'b1;
          flush_ID = (req_src != SRC_JMP);
          npc      = req_tgt;
          stall_PC = ~imem_ready;
          if (!imem_ready) begin
            pend_d  = req_tgt;
            tag_d   = req_src;
            state_d = ST_WAIT;
          end
        end else begin
          npc      = pc + 32'd4;
          stall_PC = ~imem_ready | hazard_stall;
        end
      end
      ST_WAIT: begin
        flush_IF = 1'b1;
        flush_ID = 1'b0;
        npc      = pend_q;
        stall_PC = ~imem_ready;
        // Branch/trap always replace the latched target; a jump never beats one.
        take_new = (req_src != SRC_NONE) && ((req_src > tag_q) || (req_src >= SRC_BR));
        if (take_new) begin
          flush_ID = (req_src != SRC_JMP);
          npc      = req_tgt;
        end
        if (imem_ready) begin
          state_d = ST_RUN;
          pend_d  = '0;
          tag_d   = SRC_NONE;
        end else if (take_new) begin
          pend_d = req_tgt;
          tag_d  = req_src;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  assign redirect_pending = (state_q == ST_WAIT);
  assign boot_done        = (state_q != ST_BOOT);

`ifdef PC_ALIGN_CHECK_EN
  assign misalign_err = req_misalign & (state_q != ST_BOOT);
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle-level reference model checked every
// negedge, plus literal expectations for each directed vector.
module tb_pc_sequencer;

  localparam logic [31:0] RST_VEC  = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0004;
  localparam int          BOOT_N   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc = '0;
  logic        imem_ready = 1'b1;
  logic        hazard_stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        trap_req = 1'b0;
  logic [31:0] npc;
  logic        stall_PC, flush_IF, flush_ID, redirect_pending, boot_done, misalign_err;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(
    .RESET_VECTOR(RST_VEC),
    .TRAP_VECTOR (TRAP_VEC),
    .BOOT_CYCLES (BOOT_N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .imem_ready      (imem_ready),
    .hazard_stall    (hazard_stall),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .jmp_valid       (jmp_valid),
    .jmp_target      (jmp_target),
    .trap_req        (trap_req),
    .npc             (npc),
    .stall_PC        (stall_PC),
    .flush_IF        (flush_IF),
    .flush_ID        (flush_ID),
    .redirect_pending(redirect_pending),
    .boot_done       (boot_done),
    .misalign_err    (misalign_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model state: boot cycles still to serve, and one remembered redirect.
  int          boot_left = BOOT_N;
  bit          m_pend = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_rank = 0;

  logic [31:0] e_npc;
  bit          e_stall, e_fif, e_fid, e_rp, e_bd, e_mis;
  bit          nx_pend;
  logic [31:0] nx_addr;
  int          nx_rank;

  function automatic void model_eval();
    int          rank;
    logic [31:0] tgt;
    bit          mis;
    bit          accept;
    rank = 0; tgt = '0; mis = 1'b0;
    // Later assignments win, giving trap > branch > jump.
    if (jmp_valid) begin rank = 1; tgt = jmp_target; end
    if (br_taken)  begin rank = 2; tgt = br_target;  end
    if (trap_req)  begin rank = 3; tgt = TRAP_VEC;   end
`ifdef PC_ALIGN_CHECK_EN
    if ((rank == 1 || rank == 2) && (tgt % 4) != 0) begin
      rank = 3; tgt = TRAP_VEC; mis = 1'b1;
    end
`endif
    nx_pend = m_pend; nx_addr = m_addr; nx_rank = m_rank;
    e_rp = 1'b0; e_bd = 1'b1; e_mis = 1'b0;
    if (!rst_n || boot_left > 0) begin
      e_npc = RST_VEC; e_stall = 1'b1; e_fif = 1'b1; e_fid = 1'b1; e_bd = 1'b0;
    end else if (!m_pend) begin
      e_mis = mis;
      if (rank > 0) begin
        e_npc = tgt; e_stall = !imem_ready; e_fif = 1'b1; e_fid = (rank >= 2);
        if (!imem_ready) begin nx_pend = 1'b1; nx_addr = tgt; nx_rank = rank; end
      end else begin
        e_npc   = 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
        e_stall = !imem_ready || hazard_stall;
        e_fif   = 1'b0; e_fid = 1'b0;
      end
    end else begin
      e_mis = mis;
      e_rp = 1'b1; e_fif = 1'b1; e_fid = 1'b0; e_stall = !imem_ready;
      accept = (rank > 0) && (rank > m_rank || rank >= 2);
      e_npc = accept ? tgt : m_addr;
      if (accept) e_fid = 1'b1;
      if (imem_ready) begin
        nx_pend = 1'b0; nx_rank = 0;
      end else if (accept) begin
        nx_addr = tgt; nx_rank = rank;
      end
    end
  endfunction

  always @(negedge rst_n) begin
    boot_left = BOOT_N; m_pend = 1'b0; m_rank = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      boot_left = BOOT_N; m_pend = 1'b0; m_rank = 0;
    end else begin
      model_eval();
      if (boot_left > 0) boot_left--;
      else begin m_pend = nx_pend; m_addr = nx_addr; m_rank = nx_rank; end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    model_eval();
    chk32("m_npc", npc, e_npc);
    chk1("m_stall_PC", stall_PC, e_stall);
    chk1("m_flush_IF", flush_IF, e_fif);
    chk1("m_flush_ID", flush_ID, e_fid);
    chk1("m_redirect_pending", redirect_pending, e_rp);
    chk1("m_boot_done", boot_done, e_bd);
    chk1("m_misalign_err", misalign_err, e_mis);
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    hazard_stall = 1'b0; br_taken = 1'b0; br_target = '0;
    jmp_valid = 1'b0; jmp_target = '0; trap_req = 1'b0;
  endtask

  // Drive a vector (inputs change just after posedge) and wait to the negedge.
  task automatic apply(input logic [31:0] v_pc, input logic v_rdy, input logic v_hz,
                       input logic v_br, input logic [31:0] v_brt,
                       input logic v_jv, input logic [31:0] v_jt, input logic v_trap);
    pc = v_pc; imem_ready = v_rdy; hazard_stall = v_hz;
    br_taken = v_br; br_target = v_brt; jmp_valid = v_jv; jmp_target = v_jt;
    trap_req = v_trap;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0; imem_ready = 1'b1; pc = '0;
    @(negedge clk);
    chk32("rst_npc", npc, 32'h0);
    chk1("rst_stall", stall_PC, 1'b1);
    chk1("rst_flush_IF", flush_IF, 1'b1);
    chk1("rst_flush_ID", flush_ID, 1'b1);
    chk1("rst_pending", redirect_pending, 1'b0);
    chk1("rst_boot_done", boot_done, 1'b0);
    chk1("rst_misalign", misalign_err, 1'b0);
    next_cycle();
    rst_n = 1'b1;

    // Boot window: two cycles of stall at the reset vector.
    apply(32'h0, 1, 0, 0, 0, 0, 0, 0);
    chk32("boot1_npc", npc, 32'h0); chk1("boot1_stall", stall_PC, 1'b1);
    next_cycle();
    apply(32'h0, 1, 0, 0, 0, 0, 0, 0);
    chk32("boot2_npc", npc, 32'h0); chk1("boot2_done", boot_done, 1'b0);
    next_cycle();
    apply(32'h0, 1, 0, 0, 0, 0, 0, 0);
    chk32("run_npc", npc, 32'h4); chk1("run_stall", stall_PC, 1'b0);
    chk1("run_boot_done", boot_done, 1'b1);
    next_cycle();

    // Taken branch, fetch ready.
    apply(32'h10, 1, 0, 1, 32'h80, 0, 0, 0);
    chk32("br_npc", npc, 32'h80); chk1("br_fif", flush_IF, 1'b1);
    chk1("br_fid", flush_ID, 1'b1); chk1("br_stall", stall_PC, 1'b0);
    next_cycle();

    // Hazard stall alone, then overridden by a jump.
    apply(32'h20, 1, 1, 0, 0, 0, 0, 0);
    chk1("hz_stall", stall_PC, 1'b1); chk32("hz_npc", npc, 32'h24);
    chk1("hz_fif", flush_IF, 1'b0);
    next_cycle();
    apply(32'h20, 1, 1, 0, 0, 1, 32'h100, 0);
    chk1("jmp_stall", stall_PC, 1'b0); chk32("jmp_npc", npc, 32'h100);
    chk1("jmp_fif", flush_IF, 1'b1); chk1("jmp_fid", flush_ID, 1'b0);
    next_cycle();

    // Branch while imem busy; lower-priority jump is dropped.
    apply(32'h30, 0, 0, 1, 32'h200, 0, 0, 0);
    chk1("wb1_stall", stall_PC, 1'b1); chk1("wb1_rp", redirect_pending, 1'b0);
    next_cycle();
    apply(32'h30, 0, 0, 0, 0, 1, 32'h300, 0);
    chk1("wb2_rp", redirect_pending, 1'b1); chk32("wb2_npc", npc, 32'h200);
    chk1("wb2_stall", stall_PC, 1'b1);
    next_cycle();
    apply(32'h30, 0, 0, 0, 0, 0, 0, 0);
    chk32("wb3_npc", npc, 32'h200);
    next_cycle();
    apply(32'h30, 1, 0, 0, 0, 0, 0, 0);
    chk32("wb4_npc", npc, 32'h200); chk1("wb4_stall", stall_PC, 1'b0);
    next_cycle();
    apply(32'h200, 1, 0, 0, 0, 0, 0, 0);
    chk1("wb5_rp", redirect_pending, 1'b0); chk32("wb5_npc", npc, 32'h204);
    next_cycle();

    // Trap beats branch; PC wrap.
    apply(32'h204, 1, 0, 1, 32'h80, 0, 0, 1);
    chk32("trap_npc", npc, 32'h4); chk1("trap_fid", flush_ID, 1'b1);
    next_cycle();
    apply(32'hFFFF_FFFC, 1, 0, 0, 0, 0, 0, 0);
    chk32("wrap_npc", npc, 32'h0);
    next_cycle();

    // Pending jump overwritten by a branch.
    apply(32'h40, 0, 0, 0, 0, 1, 32'h500, 0);
    next_cycle();
    apply(32'h40, 0, 0, 1, 32'h600, 0, 0, 0);
    chk32("ow_npc", npc, 32'h600); chk1("ow_fid", flush_ID, 1'b1);
    next_cycle();
    apply(32'h40, 1, 0, 0, 0, 0, 0, 0);
    chk32("ow_replay_npc", npc, 32'h600); chk1("ow_replay_stall", stall_PC, 1'b0);
    next_cycle();

    // New trap together with imem_ready while waiting on a jump.
    apply(32'h50, 0, 0, 0, 0, 1, 32'h700, 0);
    next_cycle();
    apply(32'h50, 1, 0, 0, 0, 0, 0, 1);
    chk32("sim_npc", npc, 32'h4); chk1("sim_stall", stall_PC, 1'b0);
    next_cycle();
    apply(32'h4, 1, 0, 0, 0, 0, 0, 0);
    chk1("sim_rp", redirect_pending, 1'b0); chk32("sim_after_npc", npc, 32'h8);
    next_cycle();

    // Reset while waiting: pending discarded.
    apply(32'h60, 0, 0, 1, 32'h900, 0, 0, 0);
    next_cycle();
    idle_inputs(); imem_ready = 1'b0;
    chk1("rw_rp_before", redirect_pending, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("rw_rp", redirect_pending, 1'b0); chk32("rw_npc", npc, 32'h0);
    chk1("rw_stall", stall_PC, 1'b1); chk1("rw_boot_done", boot_done, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < BOOT_N; i++) begin
      apply(32'h0, 1, 0, 0, 0, 0, 0, 0);
      chk1("rw_boot_stall", stall_PC, 1'b1);
      next_cycle();
    end
    apply(32'h70, 1, 0, 0, 0, 0, 0, 0);
    chk32("rw_run_npc", npc, 32'h74); chk1("rw_run_rp", redirect_pending, 1'b0);
    next_cycle();

    // Misaligned branch target.
    apply(32'h80, 1, 0, 1, 32'h82, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk32("mis_npc", npc, 32'h4); chk1("mis_err", misalign_err, 1'b1);
`else
    chk32("mis_npc", npc, 32'h82); chk1("mis_err", misalign_err, 1'b0);
`endif
    next_cycle();
    apply(32'h84, 1, 0, 0, 0, 0, 0, 0);
    chk1("mis_err_after", misalign_err, 1'b0);
    next_cycle();

    idle_inputs();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
